// File: rtl/mips_cpu_mem_arbiter.sv
// rtl/mips_cpu_mem_arbiter.sv - fetch/data arbiter and bus FSM for the multicycle core's single memory master
module mips_cpu_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  // instruction-fetch requester
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic [DATA_W-1:0]     i_rdata,
  output logic                  i_done,
  // data (load/store) requester
  input  logic                  d_req,
  input  logic                  d_write,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_byteenable,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_done,
  // memory master port
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [DATA_W-1:0]     avm_writedata,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_waitrequest,
  // status
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int BE_W = DATA_W / 8;

  // Watchdog counter only needs to reach TIMEOUT-1; the abort fires on the
  // stall cycle that would bring it to TIMEOUT.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int WD_LAST_INT = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WD_LAST_INT);
  localparam bit WD_ON = (TIMEOUT != 0);
  localparam bit DATA_FIRST = (FIXED_PRIO != 0);

  // last_grant encoding: which requester completed most recently
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              last_grant;
  logic [CNT_W-1:0]  wait_cnt;

  logic              grant_i;
  logic              grant_d;
  logic              accept;
  logic              abort;
  logic              finish;
  logic              in_bus;

  assign in_bus = (state == BUS_I) || (state == BUS_D);
  assign finish = accept || abort;
  assign busy   = (state != IDLE);

  // State register; reset also aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Arbitration and bus-phase decisions.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    accept     = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        // Data wins if alone, if it has fixed priority, or if fetch went last.
        if (d_req && (!i_req || DATA_FIRST || (last_grant == PORT_I))) begin
          grant_d    = 1'b1;
          state_next = BUS_D;
        end else if (i_req) begin
          grant_i    = 1'b1;
          state_next = BUS_I;
        end
      end
      BUS_I, BUS_D: begin
        accept = !avm_waitrequest;
        abort  = avm_waitrequest && WD_ON && (wait_cnt == WD_LAST);
        if (accept || abort) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // Requests are deliberately ignored here so a requester can drop req.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Count consecutive stalled bus cycles for the current transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (grant_i || grant_d) begin
      wait_cnt <= '0;
    end else if (in_bus && avm_waitrequest) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Command launch: latch the granted requester onto the memory port.
  always_ff @(posedge clk) begin
    if (reset) begin
      avm_address    <= '0;
      avm_writedata  <= '0;
      avm_byteenable <= '0;
    end else if (grant_d) begin
      avm_address    <= d_addr;
      avm_writedata  <= d_wdata;
      avm_byteenable <= d_byteenable;
    end else if (grant_i) begin
      avm_address    <= i_addr;
      avm_writedata  <= '0;
      avm_byteenable <= {BE_W{1'b1}};
    end
  end

  // Read/write strobes: set at grant, held through wait-states, dropped on finish.
  always_ff @(posedge clk) begin
    if (reset) begin
      avm_read  <= 1'b0;
      avm_write <= 1'b0;
    end else if (grant_d) begin
      avm_read  <= !d_write;
      avm_write <= d_write;
    end else if (grant_i) begin
      avm_read  <= 1'b1;
      avm_write <= 1'b0;
    end else if (finish) begin
      avm_read  <= 1'b0;
      avm_write <= 1'b0;
    end
  end

  // Completion: one-cycle done pulse, read-data capture and fairness history.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      last_grant <= PORT_I;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      if (finish) begin
        if (state == BUS_D) begin
          d_done     <= 1'b1;
          last_grant <= PORT_D;
          // Stores leave the previous load result untouched.
          if (avm_read) begin
            d_rdata <= abort ? '0 : avm_readdata;
          end
        end else begin
          i_done     <= 1'b1;
          last_grant <= PORT_I;
          i_rdata    <= abort ? '0 : avm_readdata;
        end
      end
    end
  end

  // Sticky watchdog flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else if (abort) begin
      timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// tb/tb_mips_cpu_mem_arbiter.sv - bench for mips_cpu_mem_arbiter (round-robin/TIMEOUT=4 and fixed-priority/TIMEOUT=255 instances)
module tb_mips_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_req;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byteenable;

  int          mem_wait;
  logic [31:0] mem_rdata;
  bit          started;

  logic [31:0] avm_address     [2];
  logic        avm_read        [2];
  logic        avm_write       [2];
  logic [31:0] avm_writedata   [2];
  logic [3:0]  avm_byteenable  [2];
  logic [31:0] avm_readdata    [2];
  logic        avm_waitrequest [2];
  logic [31:0] i_rdata         [2];
  logic [31:0] d_rdata         [2];
  logic        i_done          [2];
  logic        d_done          [2];
  logic        busy            [2];
  logic        timeout_err     [2];

  int n_cmp;
  int n_bad;

  always #5 clk = ~clk;

  // Instance 0: round-robin, TIMEOUT=4. Instance 1: data priority, TIMEOUT=255.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    int wcnt;

    mips_cpu_mem_arbiter #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .FIXED_PRIO(g),
      .TIMEOUT   ((g == 0) ? 4 : 255)
    ) dut (
      .clk            (clk),
      .reset          (reset),
      .i_req          (i_req),
      .i_addr         (i_addr),
      .i_rdata        (i_rdata[g]),
      .i_done         (i_done[g]),
      .d_req          (d_req),
      .d_write        (d_write),
      .d_addr         (d_addr),
      .d_wdata        (d_wdata),
      .d_byteenable   (d_byteenable),
      .d_rdata        (d_rdata[g]),
      .d_done         (d_done[g]),
      .avm_address    (avm_address[g]),
      .avm_read       (avm_read[g]),
      .avm_write      (avm_write[g]),
      .avm_writedata  (avm_writedata[g]),
      .avm_byteenable (avm_byteenable[g]),
      .avm_readdata   (avm_readdata[g]),
      .avm_waitrequest(avm_waitrequest[g]),
      .busy           (busy[g]),
      .timeout_err    (timeout_err[g])
    );

    // Memory: stalls the first mem_wait cycles of every command.
    assign avm_waitrequest[g] = (avm_read[g] || avm_write[g]) && (wcnt < mem_wait);
    assign avm_readdata[g]    = mem_rdata ^ {24'h0, avm_address[g][7:0]};

    always @(posedge clk) begin
      wcnt <= (avm_read[g] || avm_write[g]) ? wcnt + 1 : 0;
    end
  end

  // Transaction-level model: a grant occupies the bus for a known number of
  // cycles (wait-states + 1, or TIMEOUT when the memory never answers),
  // followed by one completion cycle.
  int          m_busy [2];
  int          m_cmd  [2];
  bit          m_to   [2];
  bit          m_port [2];
  bit          m_rd   [2];
  bit          m_last [2];
  logic [31:0] e_addr [2];
  logic [31:0] e_wd   [2];
  logic [3:0]  e_be   [2];
  logic        e_rd   [2];
  logic        e_wr   [2];
  logic [31:0] e_ird  [2];
  logic [31:0] e_drd  [2];
  logic        e_idone[2];
  logic        e_ddone[2];
  logic        e_err  [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      automatic int  tmo    = (k == 0) ? 4 : 255;
      automatic bit  stuck  = (tmo != 0) && (mem_wait >= tmo);
      automatic int  len    = stuck ? tmo : mem_wait + 1;
      automatic bit  take_d = d_req && (!i_req || (k == 1) || !m_last[k]);
      automatic logic [31:0] word = m_to[k] ? 32'h0 : (mem_rdata ^ {24'h0, e_addr[k][7:0]});
      e_idone[k] <= 1'b0;
      e_ddone[k] <= 1'b0;
      if (reset) begin
        m_busy[k] <= 0;
        m_cmd[k]  <= 0;
        m_to[k]   <= 1'b0;
        m_port[k] <= 1'b0;
        m_rd[k]   <= 1'b0;
        m_last[k] <= 1'b0;
        e_addr[k] <= '0;
        e_wd[k]   <= '0;
        e_be[k]   <= '0;
        e_rd[k]   <= 1'b0;
        e_wr[k]   <= 1'b0;
        e_ird[k]  <= '0;
        e_drd[k]  <= '0;
        e_err[k]  <= 1'b0;
      end else if (m_busy[k] == 0) begin
        if (i_req || d_req) begin
          m_port[k] <= take_d;
          m_to[k]   <= stuck;
          m_rd[k]   <= take_d ? !d_write : 1'b1;
          m_cmd[k]  <= len;
          m_busy[k] <= len + 1;
          e_addr[k] <= take_d ? d_addr : i_addr;
          e_wd[k]   <= take_d ? d_wdata : 32'h0;
          e_be[k]   <= take_d ? d_byteenable : 4'hF;
          e_rd[k]   <= take_d ? !d_write : 1'b1;
          e_wr[k]   <= take_d && d_write;
        end
      end else begin
        m_busy[k] <= m_busy[k] - 1;
        if (m_cmd[k] == 1) begin
          m_cmd[k]  <= 0;
          e_rd[k]   <= 1'b0;
          e_wr[k]   <= 1'b0;
          m_last[k] <= m_port[k];
          if (m_to[k]) e_err[k] <= 1'b1;
          if (m_port[k]) begin
            e_ddone[k] <= 1'b1;
            if (m_rd[k]) e_drd[k] <= word;
          end else begin
            e_idone[k] <= 1'b1;
            e_ird[k]   <= word;
          end
        end else if (m_cmd[k] > 1) begin
          m_cmd[k] <= m_cmd[k] - 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_str(input string nm, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %s expected %s", nm, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("d%0d.avm_address", k), avm_address[k], e_addr[k]);
        chk($sformatf("d%0d.avm_read", k), avm_read[k], e_rd[k]);
        chk($sformatf("d%0d.avm_write", k), avm_write[k], e_wr[k]);
        chk($sformatf("d%0d.avm_writedata", k), avm_writedata[k], e_wd[k]);
        chk($sformatf("d%0d.avm_byteenable", k), avm_byteenable[k], e_be[k]);
        chk($sformatf("d%0d.i_rdata", k), i_rdata[k], e_ird[k]);
        chk($sformatf("d%0d.d_rdata", k), d_rdata[k], e_drd[k]);
        chk($sformatf("d%0d.i_done", k), i_done[k], e_idone[k]);
        chk($sformatf("d%0d.d_done", k), d_done[k], e_ddone[k]);
        chk($sformatf("d%0d.busy", k), busy[k], m_busy[k] != 0);
        chk($sformatf("d%0d.timeout_err", k), timeout_err[k], e_err[k]);
        chk($sformatf("d%0d.rw_exclusive", k), avm_read[k] && avm_write[k], 1'b0);
        chk($sformatf("d%0d.done_exclusive", k), i_done[k] && d_done[k], 1'b0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise a request, hold it until instance 0 reports done, drop it in the done cycle.
  task automatic xfer(input bit is_d, output int lat, output bit seen,
                      output int wr_cyc, output int i_pulses);
    lat = 0;
    seen = 1'b0;
    wr_cyc = 0;
    i_pulses = 0;
    if (is_d) d_req = 1'b1; else i_req = 1'b1;
    while (!seen && lat < 40) begin
      tick();
      lat++;
      if (avm_write[0]) wr_cyc++;
      if (i_done[0]) i_pulses++;
      seen = is_d ? d_done[0] : i_done[0];
    end
    d_req = 1'b0;
    i_req = 1'b0;
  endtask

  initial begin
    int    lat;
    bit    seen;
    int    wr_cyc;
    int    ipul;
    string seq0;
    string seq1;

    n_cmp = 0;
    n_bad = 0;
    started = 1'b0;
    reset = 1'b1;
    i_req = 1'b0;
    i_addr = '0;
    d_req = 1'b0;
    d_write = 1'b0;
    d_addr = '0;
    d_wdata = '0;
    d_byteenable = '0;
    mem_wait = 0;
    mem_rdata = '0;
    tick();
    started = 1'b1;
    tick();
    chk("reset_busy", busy[0], 1'b0);
    chk("reset_avm_read", avm_read[0], 1'b0);
    reset = 1'b0;
    tick();

    // Single zero-wait fetch from the boot vector.
    mem_rdata = 32'h2402_0005;
    i_addr = 32'hBFC0_0000;
    xfer(1'b0, lat, seen, wr_cyc, ipul);
    chk("fetch_done_seen", seen, 1'b1);
    chk("fetch_latency", lat, 2);
    chk("fetch_rdata", i_rdata[0], 32'h2402_0005);
    chk("model_fetch_rdata", e_ird[0], 32'h2402_0005);
    tick();

    // Store with three wait-states.
    mem_wait = 3;
    d_write = 1'b1;
    d_addr = 32'h0000_1000;
    d_wdata = 32'hDEAD_BEEF;
    d_byteenable = 4'b0011;
    xfer(1'b1, lat, seen, wr_cyc, ipul);
    chk("store_done_seen", seen, 1'b1);
    chk("store_latency", lat, 5);
    chk("store_write_cycles", wr_cyc, 4);
    chk("store_no_fetch_done", ipul, 0);
    chk("store_rdata_kept", d_rdata[0], 32'h0);
    chk("store_writedata", avm_writedata[0], 32'hDEAD_BEEF);
    tick();

    // Both requesters held from reset: round-robin vs data priority.
    reset = 1'b1;
    i_req = 1'b1;
    d_req = 1'b1;
    d_write = 1'b0;
    d_addr = 32'h0000_2000;
    i_addr = 32'h0000_3000;
    mem_wait = 0;
    mem_rdata = 32'h1111_0000;
    tick();
    tick();
    reset = 1'b0;
    seq0 = "";
    seq1 = "";
    for (int c = 0; c < 17; c++) begin
      tick();
      if (c == 11) d_req = 1'b0;
      if (c == 12) i_req = 1'b0;
      if (i_done[0]) seq0 = {seq0, "I"};
      if (d_done[0]) seq0 = {seq0, "D"};
      if (i_done[1]) seq1 = {seq1, "I"};
      if (d_done[1]) seq1 = {seq1, "D"};
    end
    chk_str("grant_order_rr", seq0, "DIDII");
    chk_str("grant_order_fixed", seq1, "DDDDI");
    chk("rr_load_rdata", d_rdata[0], 32'h1111_0000);

    // Load into a memory that never answers.
    mem_wait = 1000;
    d_write = 1'b0;
    d_addr = 32'h0000_0044;
    mem_rdata = 32'hCAFE_0000;
    d_req = 1'b1;
    tick();
    d_req = 1'b0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      tick();
      lat++;
      seen = d_done[0];
    end
    chk("timeout_done_seen", seen, 1'b1);
    chk("timeout_stall_cycles", lat, 4);
    chk("timeout_rdata_zero", d_rdata[0], 32'h0);
    chk("timeout_err_set", timeout_err[0], 1'b1);
    chk("model_timeout_err", e_err[0], 1'b1);
    repeat (300) tick();
    chk("timeout_err_sticky", timeout_err[0], 1'b1);
    chk("timeout255_err", timeout_err[1], 1'b1);
    chk("timeout255_rdata_zero", d_rdata[1], 32'h0);

    // Reset in the middle of a stalled load.
    d_req = 1'b1;
    tick();
    d_req = 1'b0;
    tick();
    tick();
    chk("midbus_busy", busy[0], 1'b1);
    chk("midbus_read", avm_read[0], 1'b1);
    reset = 1'b1;
    tick();
    chk("abort_read", avm_read[0], 1'b0);
    chk("abort_busy", busy[0], 1'b0);
    chk("abort_no_done", d_done[0], 1'b0);
    chk("abort_err_cleared", timeout_err[0], 1'b0);
    reset = 1'b0;
    tick();

    // Fresh fetch after the aborted transfer.
    mem_wait = 0;
    mem_rdata = 32'h1234_5600;
    i_addr = 32'h0000_0040;
    xfer(1'b0, lat, seen, wr_cyc, ipul);
    chk("refetch_done_seen", seen, 1'b1);
    chk("refetch_latency", lat, 2);
    chk("refetch_rdata", i_rdata[0], 32'h1234_5640);
    chk("refetch_rdata_fixed", i_rdata[1], 32'h1234_5640);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
